// File: rtl/decode_pkg.sv
// decode_pkg: shared field widths, condition codes and helpers for the decode stage
package decode_pkg;
  localparam int INST_W_D = 16;
  localparam int COND_W_D = 2;
  localparam int OPC_W_D = 4;
  localparam int REG_W_D = 3;
  localparam int DEPTH_D = 4;
  localparam logic [1:0] COND_ALWAYS = 2'b00;
  localparam logic [1:0] COND_Z = 2'b01;
  localparam logic [1:0] COND_NZ = 2'b10;
  localparam logic [1:0] COND_N = 2'b11;
  function automatic int shift_width(input int iw, input int cw, input int ow, input int rw);
    return iw - cw - ow - rw;
  endfunction
  // Codes beyond the four defined ones mean "never"
  function automatic logic cond_pass(input logic [31:0] c, input logic z, input logic n);
    return c == 32'(COND_ALWAYS) ? 1'b1 :
           c == 32'(COND_Z)      ? z    :
           c == 32'(COND_NZ)     ? ~z   :
           c == 32'(COND_N)      ? n    : 1'b0;
  endfunction
endpackage

// File: rtl/decode_if.sv
// decode_if: fetch-side and execute-side handshake bundle of the decode stage
interface decode_if import decode_pkg::*; #(
  parameter int INST_W = INST_W_D,
  parameter int COND_W = COND_W_D,
  parameter int OPC_W = OPC_W_D,
  parameter int REG_W = REG_W_D,
  parameter int DEPTH = DEPTH_D
);
  localparam int SHIFT_W = shift_width(INST_W, COND_W, OPC_W, REG_W);
  logic flush;
  logic in_valid;
  logic in_ready;
  logic [INST_W-1:0] in_inst;
  logic out_valid;
  logic out_ready;
  logic [COND_W-1:0] cond;
  logic [OPC_W-1:0] op_code;
  logic [REG_W-1:0] dest_reg;
  logic [REG_W-1:0] src_reg_1;
  logic [REG_W-1:0] src_reg_2;
  logic [SHIFT_W-1:0] shift;
  logic flag_z;
  logic flag_n;
  logic exec_en;
  logic [$clog2(DEPTH):0] occupancy;
  modport master (
    output flush, in_valid, in_inst, out_ready, flag_z, flag_n,
    input in_ready, out_valid, cond, op_code, dest_reg, src_reg_1, src_reg_2, shift, exec_en, occupancy
  );
  modport slave (
    input flush, in_valid, in_inst, out_ready, flag_z, flag_n,
    output in_ready, out_valid, cond, op_code, dest_reg, src_reg_1, src_reg_2, shift, exec_en, occupancy
  );
endinterface

// File: rtl/inst_fifo.sv
// inst_fifo: DEPTH-entry instruction queue with occupancy count and synchronous clear
module inst_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_clr,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [W-1:0]             i_din,
  output logic [W-1:0]             o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_count <= '0;
    end else if (i_clr) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + AW'(1);
      if (i_pop) r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr] <= i_din;
  end
  assign o_dout = r_mem[r_rptr];
  assign o_full = r_count == CW'(DEPTH);
  assign o_empty = r_count == '0;
  assign o_count = r_count;
endmodule

// File: rtl/decode_stage.sv
// decode_stage: buffered instruction decode between fetch and execute,
// field slicing from a held output word and condition-gated execute enable
module decode_stage import decode_pkg::*; #(
  parameter int INST_W = INST_W_D,
  parameter int COND_W = COND_W_D,
  parameter int OPC_W = OPC_W_D,
  parameter int REG_W = REG_W_D,
  parameter int DEPTH = DEPTH_D
) (
  input logic clk,
  input logic rst_n,
  decode_if.slave bus
);
  localparam int SHIFT_W = shift_width(INST_W, COND_W, OPC_W, REG_W);
  if (SHIFT_W < 2 * REG_W) begin : g_bad_shift
    $error("decode_stage: SHIFT_W (%0d) must be >= 2*REG_W (%0d)", SHIFT_W, 2 * REG_W);
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("decode_stage: DEPTH (%0d) must be a power of two >= 2", DEPTH);
  end
  logic w_push;
  logic w_pop;
  logic w_full;
  logic w_empty;
  logic [INST_W-1:0] w_head;
  logic [COND_W-1:0] w_cond;
  logic r_valid;
  logic [INST_W-1:0] r_inst;
  // Flush suppresses both handshakes; in_ready still reflects only fullness
  assign w_push = bus.in_valid & ~w_full & ~bus.flush;
  assign w_pop = ~w_empty & (~r_valid | bus.out_ready) & ~bus.flush;
  inst_fifo #(.DEPTH(DEPTH), .W(INST_W)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .i_clr(bus.flush),
    .i_push(w_push),
    .i_pop(w_pop),
    .i_din(bus.in_inst),
    .o_dout(w_head),
    .o_full(w_full),
    .o_empty(w_empty),
    .o_count(bus.occupancy)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_inst <= '0;
    end else if (bus.flush) begin
      r_valid <= 1'b0;
      r_inst <= '0;
    end else if (w_pop) begin
      r_valid <= 1'b1;
      r_inst <= w_head;
    end else if (bus.out_ready) begin
      r_valid <= 1'b0;
    end
  end
  assign w_cond = r_inst[INST_W-1 -: COND_W];
  assign bus.in_ready = ~w_full;
  assign bus.out_valid = r_valid;
  assign bus.cond = w_cond;
  assign bus.op_code = r_inst[INST_W-COND_W-1 -: OPC_W];
  assign bus.dest_reg = r_inst[SHIFT_W+REG_W-1 -: REG_W];
  assign bus.src_reg_1 = r_inst[SHIFT_W-1 -: REG_W];
  assign bus.src_reg_2 = r_inst[SHIFT_W-1-REG_W -: REG_W];
  assign bus.shift = r_inst[SHIFT_W-1:0];
  assign bus.exec_en = r_valid & cond_pass(32'(w_cond), bus.flag_z, bus.flag_n);
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed self-checking bench for decode_stage (16-bit and 24-bit builds)
module tb_decode_stage;
  logic clk = 1'b0;
  logic rst_n;
  int n_checks = 0;
  int n_fail = 0;
  always #5 clk = ~clk;

  decode_if #(.INST_W(16), .COND_W(2), .OPC_W(4), .REG_W(3), .DEPTH(4)) bus ();
  decode_if #(.INST_W(24), .COND_W(2), .OPC_W(6), .REG_W(5), .DEPTH(4)) bus2 ();
  decode_stage #(.INST_W(16), .COND_W(2), .OPC_W(4), .REG_W(3), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
  decode_stage #(.INST_W(24), .COND_W(2), .OPC_W(6), .REG_W(5), .DEPTH(4)) dut_w (
    .clk(clk), .rst_n(rst_n), .bus(bus2));

  logic [21:0] f;
  assign f = {bus.cond, bus.op_code, bus.dest_reg, bus.src_reg_1, bus.src_reg_2, bus.shift};

  function automatic logic [21:0] exp_f(input logic [15:0] w);
    return {w[15:14], w[13:10], w[9:7], w[6:4], w[3:1], w[6:0]};
  endfunction

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
    n_checks++; if (bus.occupancy !== 3'd0) begin n_fail++; $display("FAIL reset_occupancy got %0d exp 0", bus.occupancy); end
    n_checks++; if (f !== 22'd0) begin n_fail++; $display("FAIL reset_fields got %h exp 0", f); end
    n_checks++; if (bus.exec_en !== 1'b0) begin n_fail++; $display("FAIL reset_exec_en got %b exp 0", bus.exec_en); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_decode();
    bus.in_valid = 1'b1; bus.in_inst = 16'h4EAD; bus.out_ready = 1'b1; bus.flag_z = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL decode_latency got %b exp 0", bus.out_valid); end
    @(negedge clk);
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL decode_out_valid got %b exp 1", bus.out_valid); end
    n_checks++; if (f !== {2'd1, 4'd3, 3'd5, 3'd2, 3'd6, 7'h2D}) begin n_fail++; $display("FAIL decode_fields got %h exp %h", f, {2'd1, 4'd3, 3'd5, 3'd2, 3'd6, 7'h2D}); end
    n_checks++; if (bus.exec_en !== 1'b1) begin n_fail++; $display("FAIL decode_exec_z1 got %b exp 1", bus.exec_en); end
    bus.flag_z = 1'b0; #1;
    n_checks++; if (bus.exec_en !== 1'b0) begin n_fail++; $display("FAIL decode_exec_z0 got %b exp 0", bus.exec_en); end
    @(negedge clk);
    n_checks++; if (bus.out_valid !== 1'b0 || bus.occupancy !== 3'd0) begin n_fail++; $display("FAIL decode_drain got valid %b occ %0d exp 0 0", bus.out_valid, bus.occupancy); end
  endtask

  task automatic test_backpressure();
    logic [15:0] w [5];
    w = '{16'h1234, 16'hA5A5, 16'h0F0F, 16'hDEAD, 16'h7777};
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1; bus.in_inst = w[i];
      @(negedge clk);
    end
    bus.in_inst = 16'hBEEF;
    for (int k = 0; k < 2; k++) begin
      n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready got %b exp 0", bus.in_ready); end
      n_checks++; if (bus.occupancy !== 3'd4) begin n_fail++; $display("FAIL bp_occupancy got %0d exp 4", bus.occupancy); end
      n_checks++; if (bus.out_valid !== 1'b1 || f !== exp_f(w[0])) begin n_fail++; $display("FAIL bp_hold got %b %h exp 1 %h", bus.out_valid, f, exp_f(w[0])); end
      @(negedge clk);
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      n_checks++; if (bus.out_valid !== 1'b1 || f !== exp_f(w[k])) begin n_fail++; $display("FAIL bp_order%0d got %b %h exp 1 %h", k, bus.out_valid, f, exp_f(w[k])); end
      @(negedge clk);
    end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_extra got %b exp 0", bus.out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] words [32];
    logic [15:0] q [$];
    int sent = 0;
    int got = 0;
    int max_occ = 0;
    for (int i = 0; i < 32; i++) words[i] = 16'($urandom);
    for (int cyc = 0; cyc < 400 && got < 32; cyc++) begin
      bus.in_valid = sent < 32;
      bus.in_inst = sent < 32 ? words[sent] : 16'h0;
      bus.out_ready = 1'($urandom_range(0, 1));
      #1;
      if (bus.out_valid && bus.out_ready) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL stream_dup%0d got %h exp none", got, f);
        end else begin
          if (f !== exp_f(q[0])) begin n_fail++; $display("FAIL stream_word%0d got %h exp %h", got, f, exp_f(q[0])); end
          void'(q.pop_front());
        end
        got++;
      end
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(words[sent]);
        sent++;
      end
      if (int'(bus.occupancy) > max_occ) max_occ = int'(bus.occupancy);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    n_checks++; if (got != 32 || q.size() != 0) begin n_fail++; $display("FAIL stream_count got %0d left %0d exp 32 0", got, q.size()); end
    n_checks++; if (max_occ > 4) begin n_fail++; $display("FAIL stream_max_occ got %0d exp <=4", max_occ); end
  endtask

  task automatic present(input logic [15:0] w);
    bus.out_ready = 1'b1; bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_inst = w;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.out_valid !== 1'b1 || f !== exp_f(w)) begin n_fail++; $display("FAIL present_%h got %b %h exp 1 %h", w, bus.out_valid, f, exp_f(w)); end
  endtask

  task automatic test_cond();
    present(16'hC123);
    for (int i = 0; i < 4; i++) begin
      bus.flag_n = i[0]; bus.flag_z = i[1]; #1;
      n_checks++; if (bus.exec_en !== i[0]) begin n_fail++; $display("FAIL cond_n_%0d got %b exp %b", i, bus.exec_en, i[0]); end
    end
    present(16'h3ABC);
    for (int i = 0; i < 4; i++) begin
      bus.flag_n = i[0]; bus.flag_z = i[1]; #1;
      n_checks++; if (bus.exec_en !== 1'b1) begin n_fail++; $display("FAIL cond_always_%0d got %b exp 1", i, bus.exec_en); end
    end
    present(16'h8000);
    for (int i = 0; i < 2; i++) begin
      bus.flag_n = 1'b0; bus.flag_z = i[0]; #1;
      n_checks++; if (bus.exec_en !== ~i[0]) begin n_fail++; $display("FAIL cond_nz_%0d got %b exp %b", i, bus.exec_en, ~i[0]); end
    end
    bus.flag_z = 1'b0; bus.out_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.out_valid !== 1'b0 || bus.exec_en !== 1'b0) begin n_fail++; $display("FAIL cond_gated got %b %b exp 0 0", bus.out_valid, bus.exec_en); end
  endtask

  task automatic test_flush();
    logic [15:0] w [4];
    w = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1; bus.in_inst = w[i];
      @(negedge clk);
    end
    bus.flush = 1'b1; bus.in_inst = 16'h5555;
    n_checks++; if (bus.occupancy !== 3'd3 || bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL flush_pre got occ %0d valid %b exp 3 1", bus.occupancy, bus.out_valid); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready got %b exp 1", bus.in_ready); end
    @(negedge clk);
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b0 || bus.occupancy !== 3'd0) begin n_fail++; $display("FAIL flush_post got valid %b occ %0d exp 0 0", bus.out_valid, bus.occupancy); end
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_dropped%0d got %b %h exp 0", k, bus.out_valid, f); end
    end
  endtask

  task automatic test_async_reset();
    bus.out_ready = 1'b0; bus.flag_z = 1'b0; bus.flag_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1; bus.in_inst = 16'h0ACE + 16'(i);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    n_checks++; if (bus.occupancy !== 3'd2 || bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL arst_pre got occ %0d valid %b exp 2 1", bus.occupancy, bus.out_valid); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (bus.out_valid !== 1'b0 || bus.occupancy !== 3'd0 || bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL arst_immediate got valid %b occ %0d rdy %b exp 0 0 1", bus.out_valid, bus.occupancy, bus.in_ready); end
    n_checks++; if (f !== 22'd0 || bus.exec_en !== 1'b0) begin n_fail++; $display("FAIL arst_fields got %h %b exp 0 0", f, bus.exec_en); end
    @(negedge clk);
    rst_n = 1'b1; bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (bus.out_valid !== 1'b0 || bus.occupancy !== 3'd0) begin n_fail++; $display("FAIL arst_no_residue got valid %b occ %0d exp 0 0", bus.out_valid, bus.occupancy); end
  endtask

  task automatic test_wide();
    bus2.out_ready = 1'b1; bus2.flag_z = 1'b0; bus2.flag_n = 1'b0;
    bus2.in_valid = 1'b1; bus2.in_inst = 24'hA5C37E;
    @(negedge clk);
    bus2.in_inst = 24'h3FFFFF;
    @(negedge clk);
    bus2.in_valid = 1'b0;
    n_checks++; if (bus2.out_valid !== 1'b1 || bus2.cond !== 2'd2 || bus2.op_code !== 6'h25 || bus2.dest_reg !== 5'h18) begin n_fail++; $display("FAIL wide_a_hi got %b %h %h %h exp 1 2 25 18", bus2.out_valid, bus2.cond, bus2.op_code, bus2.dest_reg); end
    n_checks++; if (bus2.src_reg_1 !== 5'h0D || bus2.src_reg_2 !== 5'h1F || bus2.shift !== 11'h37E) begin n_fail++; $display("FAIL wide_a_lo got %h %h %h exp 0d 1f 37e", bus2.src_reg_1, bus2.src_reg_2, bus2.shift); end
    n_checks++; if (bus2.exec_en !== 1'b1) begin n_fail++; $display("FAIL wide_a_exec got %b exp 1", bus2.exec_en); end
    @(negedge clk);
    n_checks++; if (bus2.out_valid !== 1'b1 || bus2.cond !== 2'd0 || bus2.op_code !== 6'h3F || bus2.dest_reg !== 5'h1F) begin n_fail++; $display("FAIL wide_b_hi got %b %h %h %h exp 1 0 3f 1f", bus2.out_valid, bus2.cond, bus2.op_code, bus2.dest_reg); end
    n_checks++; if (bus2.src_reg_1 !== 5'h1F || bus2.src_reg_2 !== 5'h1F || bus2.shift !== 11'h7FF) begin n_fail++; $display("FAIL wide_b_lo got %h %h %h exp 1f 1f 7ff", bus2.src_reg_1, bus2.src_reg_2, bus2.shift); end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_inst = '0; bus.out_ready = 1'b0; bus.flag_z = 1'b0; bus.flag_n = 1'b0;
    bus2.flush = 1'b0; bus2.in_valid = 1'b0; bus2.in_inst = '0; bus2.out_ready = 1'b0; bus2.flag_z = 1'b0; bus2.flag_n = 1'b0;
    test_reset();
    test_decode();
    test_backpressure();
    test_back_to_back();
    test_cond();
    test_flush();
    test_async_reset();
    test_wide();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
